// File: rtl/pagerank_pkg.sv
// Shared message widths and requester-ID type for the pagerank memory subsystem.
// Widths match VC_MEM_REQ_MSG_NBITS(8,32,32) and VC_MEM_RESP_MSG_NBITS(8,32).
package pagerank_pkg;

    localparam int unsigned MEM_REQ_NBITS  = 77;
    localparam int unsigned MEM_RESP_NBITS = 47;

    typedef logic req_id_t;

endpackage

// File: rtl/pagerank_tag_fifo.sv
// In-order FIFO of requester IDs, one entry per outstanding memory request.
// Pointers wrap naturally because DEPTH is a power of two.
module pagerank_tag_fifo
    import pagerank_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic push_data,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] COUNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [PTR_W:0]   count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    req_id_t [DEPTH-1:0] tags_q;
    logic do_push, do_pop;

    assign full    = (count_q == COUNT_FULL);
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = tags_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            tags_q   <= '0;
        end else begin
            count_q <= count_d;
            if (do_push) begin
                tags_q[wr_ptr_q] <= push_data;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pagerank_mem_arbiter.sv
// Two-requester round-robin arbiter onto one in-order memory port; the tag FIFO
// remembers who issued each outstanding request so responses route back correctly.
module pagerank_mem_arbiter
    import pagerank_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic [MEM_REQ_NBITS-1:0]  req0_msg,
    input  logic                      req0_val,
    output logic                      req0_rdy,
    input  logic [MEM_REQ_NBITS-1:0]  req1_msg,
    input  logic                      req1_val,
    output logic                      req1_rdy,

    output logic [MEM_RESP_NBITS-1:0] resp0_msg,
    output logic                      resp0_val,
    input  logic                      resp0_rdy,
    output logic [MEM_RESP_NBITS-1:0] resp1_msg,
    output logic                      resp1_val,
    input  logic                      resp1_rdy,

    output logic [MEM_REQ_NBITS-1:0]  mem_req_msg,
    output logic                      mem_req_val,
    input  logic                      mem_req_rdy,

    input  logic [MEM_RESP_NBITS-1:0] mem_resp_msg,
    input  logic                      mem_resp_val,
    output logic                      mem_resp_rdy
);

    req_id_t prio_q;
    req_id_t grant;
    req_id_t head;
    logic    full, empty;
    logic    req_hs, resp_hs;

    // Contention goes to prio; otherwise the lone valid requester wins.
    assign grant = (req0_val && req1_val) ? prio_q : req1_val;

    assign mem_req_val = (req0_val | req1_val) & ~full;
    assign mem_req_msg = grant ? req1_msg : req0_msg;
    assign req0_rdy    = mem_req_rdy & ~full & (grant == 1'b0);
    assign req1_rdy    = mem_req_rdy & ~full & (grant == 1'b1);
    assign req_hs      = mem_req_val & mem_req_rdy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_q <= 1'b0;
        end else if (req_hs) begin
            prio_q <= ~grant;
        end
    end

    assign resp0_msg    = mem_resp_msg;
    assign resp1_msg    = mem_resp_msg;
    assign resp0_val    = mem_resp_val & ~empty & (head == 1'b0);
    assign resp1_val    = mem_resp_val & ~empty & (head == 1'b1);
    assign mem_resp_rdy = ~empty & (head ? resp1_rdy : resp0_rdy);
    assign resp_hs      = mem_resp_val & mem_resp_rdy;

    pagerank_tag_fifo #(
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (req_hs),
        .push_data (grant),
        .pop       (resp_hs),
        .full      (full),
        .empty     (empty),
        .head      (head)
    );

endmodule

// File: tb/tb_pagerank_mem_arbiter.sv
// Randomized bench: requesters and an in-order memory are modelled here, a queue-based
// reference predicts handshakes, and a scoreboard matches responses per port.
module tb_pagerank_mem_arbiter;
    import pagerank_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic [76:0] rmsg [2];
    logic        rval [2];
    logic        rrdy [2];
    logic        req0_rdy, req1_rdy;
    logic [46:0] resp0_msg, resp1_msg;
    logic        resp0_val, resp1_val;
    logic [76:0] mem_req_msg;
    logic        mem_req_val, mem_req_rdy;
    logic [46:0] mem_resp_msg;
    logic        mem_resp_val, mem_resp_rdy;

    always #5 clk = ~clk;

    pagerank_mem_arbiter #(
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req0_msg     (rmsg[0]),
        .req0_val     (rval[0]),
        .req0_rdy     (req0_rdy),
        .req1_msg     (rmsg[1]),
        .req1_val     (rval[1]),
        .req1_rdy     (req1_rdy),
        .resp0_msg    (resp0_msg),
        .resp0_val    (resp0_val),
        .resp0_rdy    (rrdy[0]),
        .resp1_msg    (resp1_msg),
        .resp1_val    (resp1_val),
        .resp1_rdy    (rrdy[1]),
        .mem_req_msg  (mem_req_msg),
        .mem_req_val  (mem_req_val),
        .mem_req_rdy  (mem_req_rdy),
        .mem_resp_msg (mem_resp_msg),
        .mem_resp_val (mem_resp_val),
        .mem_resp_rdy (mem_resp_rdy)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int p_val [2];
    int p_rrdy [2];
    int p_mrdy;
    int lat_lo, lat_hi, last_due;
    int acc_total = 0;
    logic hold [2];
    logic acc [2];
    logic mem_push, mem_pop;
    logic [76:0] mem_push_msg;
    logic [76:0] mem_q [$];
    int          mem_due [$];
    // Reference state: order of outstanding grants and per-port expected responses.
    logic        model_prio;
    logic        order_q [$];
    logic        grant_log [$];
    logic [46:0] exp0_q [$];
    logic [46:0] exp1_q [$];

    task automatic chk(input string name, input logic [76:0] act, input logic [76:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [76:0] new_msg(input int port);
        logic [31:0] addr;
        addr = ((port == 1) ? 32'h2000 : 32'h1000) + {22'd0, 8'($urandom), 2'b00};
        return {3'd0, 8'($urandom), addr, 2'd0, $urandom};
    endfunction

    // Memory echoes type/opaque/len and returns addr ^ data as read data.
    function automatic logic [46:0] resp_of(input logic [76:0] m);
        return {m[76:74], m[73:66], 2'b00, m[33:32], m[65:34] ^ m[31:0]};
    endfunction

    function automatic logic roll(input int pct);
        return int'($urandom_range(99, 0)) < pct;
    endfunction

    task automatic cycle();
        logic [76:0] tmp_msg;
        int          tmp_due;
        int          d;
        @(posedge clk);
        #1;
        cyc++;
        if (mem_pop) begin
            tmp_msg = mem_q.pop_front();
            tmp_due = mem_due.pop_front();
            mem_pop = 1'b0;
        end
        if (mem_push) begin
            d = cyc + int'($urandom_range(lat_hi, lat_lo));
            if (d < last_due) d = last_due;
            last_due = d;
            mem_q.push_back(mem_push_msg);
            mem_due.push_back(d);
            mem_push = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            if (acc[i]) begin
                hold[i] = 1'b0;
                acc[i]  = 1'b0;
            end
            if (!hold[i] && roll(p_val[i])) begin
                rmsg[i] = new_msg(i);
                hold[i] = 1'b1;
            end
            rval[i] = hold[i];
            rrdy[i] = roll(p_rrdy[i]);
        end
        mem_req_rdy = roll(p_mrdy);
        if (mem_q.size() > 0 && mem_due[0] <= cyc) begin
            mem_resp_val = 1'b1;
            mem_resp_msg = resp_of(mem_q[0]);
        end else begin
            mem_resp_val = 1'b0;
            mem_resp_msg = '0;
        end
    endtask

    task automatic monitor_step();
        int   n;
        logic g, hd, full_m;
        logic e_mreq_val, e_rdy0, e_rdy1, e_mresp_rdy, e_rv0, e_rv1;
        logic [46:0] tmp;
        n      = order_q.size();
        full_m = (n == int'(DEPTH));
        hd     = (n > 0) ? order_q[0] : 1'b0;
        if (rval[0] && rval[1])  g = model_prio;
        else if (rval[1])        g = 1'b1;
        else                     g = 1'b0;
        e_mreq_val  = (rval[0] || rval[1]) && !full_m;
        e_rdy0      = mem_req_rdy && !full_m && (g == 1'b0);
        e_rdy1      = mem_req_rdy && !full_m && (g == 1'b1);
        e_mresp_rdy = (n > 0) && rrdy[hd];
        e_rv0       = mem_resp_val && (n > 0) && (hd == 1'b0);
        e_rv1       = mem_resp_val && (n > 0) && (hd == 1'b1);

        chk("mem_req_val", mem_req_val, e_mreq_val);
        chk("req0_rdy", req0_rdy, e_rdy0);
        chk("req1_rdy", req1_rdy, e_rdy1);
        if (e_mreq_val) chk("mem_req_msg", mem_req_msg, rmsg[g]);
        chk("mem_resp_rdy", mem_resp_rdy, e_mresp_rdy);
        chk("resp0_val", resp0_val, e_rv0);
        chk("resp1_val", resp1_val, e_rv1);
        if (mem_resp_val) begin
            chk("resp0_msg_pass", resp0_msg, mem_resp_msg);
            chk("resp1_msg_pass", resp1_msg, mem_resp_msg);
        end

        // Scoreboard: pop whenever the DUT presents a response that is taken.
        if (resp0_val && rrdy[0]) begin
            if (exp0_q.size() == 0) begin
                total++; bad++;
                $display("FAIL resp0_sb: got %h want nothing outstanding", resp0_msg);
            end else begin
                tmp = exp0_q.pop_front();
                chk("resp0_sb", resp0_msg, tmp);
            end
        end
        if (resp1_val && rrdy[1]) begin
            if (exp1_q.size() == 0) begin
                total++; bad++;
                $display("FAIL resp1_sb: got %h want nothing outstanding", resp1_msg);
            end else begin
                tmp = exp1_q.pop_front();
                chk("resp1_sb", resp1_msg, tmp);
            end
        end

        if (!reset) begin
            if (e_mreq_val && mem_req_rdy) begin
                order_q.push_back(g);
                if (g) exp1_q.push_back(resp_of(rmsg[1]));
                else   exp0_q.push_back(resp_of(rmsg[0]));
                model_prio = ~g;
                acc[g]     = 1'b1;
                grant_log.push_back(g);
                acc_total++;
            end
            if (mem_req_val && mem_req_rdy) begin
                mem_push     = 1'b1;
                mem_push_msg = mem_req_msg;
            end
            if (mem_resp_val && e_mresp_rdy) hd = order_q.pop_front();
            if (mem_resp_val && mem_resp_rdy) mem_pop = 1'b1;
        end
    endtask

    task automatic drain();
        p_val  = '{0, 0};
        p_rrdy = '{100, 100};
        p_mrdy = 100;
        for (int k = 0; k < 400 && (order_q.size() > 0 || hold[0] || hold[1]
                                    || mem_q.size() > 0); k++) begin
            cycle();
        end
        chk("drain_done", (order_q.size() == 0) && !hold[0] && !hold[1], 1'b1);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            monitor_step();
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        logic [76:0] gl;
        for (int i = 0; i < 2; i++) begin
            rmsg[i] = '0; rval[i] = 1'b0; rrdy[i] = 1'b1; hold[i] = 1'b0; acc[i] = 1'b0;
        end
        mem_req_rdy = 1'b1; mem_resp_val = 1'b0; mem_resp_msg = '0;
        mem_push = 1'b0; mem_pop = 1'b0; mem_push_msg = '0;
        model_prio = 1'b0; last_due = 0;
        p_val = '{0, 0}; p_rrdy = '{100, 100}; p_mrdy = 100; lat_lo = 2; lat_hi = 2;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_req_val", mem_req_val, 1'b0);
        chk("rst_mem_resp_rdy", mem_resp_rdy, 1'b0);
        chk("rst_resp0_val", resp0_val, 1'b0);
        chk("rst_resp1_val", resp1_val, 1'b0);
        chk("rst_req0_rdy", req0_rdy, 1'b1);
        chk("rst_req1_rdy", req1_rdy, 1'b0);
        reset = 1'b0;

        // Lone requester 1 is granted in the same cycle.
        p_val = '{0, 100};
        cycle();
        #1;
        chk("solo1_req1_rdy", req1_rdy, 1'b1);
        chk("solo1_req0_rdy", req0_rdy, 1'b0);
        chk("solo1_msg", mem_req_msg, rmsg[1]);

        // Both continuous: strict alternation starting from port 0 after the solo grant.
        p_val = '{100, 100};
        repeat (12) cycle();
        for (int k = 0; k < 6; k++) begin
            gl = (k < grant_log.size()) ? 77'(grant_log[k]) : 'x;
            chk($sformatf("rr_order%0d", k), gl, 77'(k % 2 == 0));
        end

        // Slow memory: exactly DEPTH accepted, then stall until the first pop.
        drain();
        lat_lo = 10; lat_hi = 10; p_val = '{100, 100};
        base = acc_total;
        repeat (8) cycle();
        #1;
        chk("full_accepted", acc_total - base, 4);
        chk("full_mem_req_val", mem_req_val, 1'b0);
        chk("full_req0_rdy", req0_rdy, 1'b0);
        chk("full_req1_rdy", req1_rdy, 1'b0);
        repeat (12) cycle();
        chk("after_pop_accepted", acc_total - base > 4, 1'b1);

        // Port 0 refuses responses: head-of-line blocking, no reordering.
        drain();
        lat_lo = 1; lat_hi = 1; p_val = '{100, 100}; p_rrdy = '{0, 100};
        repeat (20) cycle();
        #1;
        chk("hol_mem_resp_rdy", mem_resp_rdy, 1'b0);
        chk("hol_mem_req_val", mem_req_val, 1'b0);
        chk("hol_resp1_val", resp1_val, 1'b0);
        drain();

        for (int ch = 0; ch < 15; ch++) begin
            p_val[0]  = int'($urandom_range(100, 0));
            p_val[1]  = int'($urandom_range(100, 0));
            p_rrdy[0] = int'($urandom_range(100, 20));
            p_rrdy[1] = int'($urandom_range(100, 20));
            p_mrdy    = int'($urandom_range(100, 20));
            lat_lo = 1; lat_hi = int'($urandom_range(12, 1));
            repeat (200) cycle();
        end
        drain();

        // Asynchronous reset with three requests outstanding.
        p_val = '{100, 100}; lat_lo = 10; lat_hi = 10;
        for (int k = 0; k < 40 && order_q.size() != 3; k++) cycle();
        #1;
        chk("pre_rst_outstanding", order_q.size(), 3);
        chk("pre_rst_mem_resp_rdy", mem_resp_rdy, 1'b1);
        order_q.delete(); exp0_q.delete(); exp1_q.delete();
        model_prio = 1'b0; mem_push = 1'b0; mem_pop = 1'b0; acc = '{1'b0, 1'b0};
        reset = 1'b1;
        mem_resp_val = 1'b1;
        mem_resp_msg = 47'h5a5a_1234_5678;
        #1;
        chk("mid_rst_mem_resp_rdy", mem_resp_rdy, 1'b0);
        chk("mid_rst_resp0_val", resp0_val, 1'b0);
        chk("mid_rst_resp1_val", resp1_val, 1'b0);
        chk("mid_rst_mem_req_val", mem_req_val, 1'b1);
        chk("mid_rst_req0_rdy", req0_rdy, 1'b1);
        chk("mid_rst_req1_rdy", req1_rdy, 1'b0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        mem_q.delete(); mem_due.delete(); last_due = cyc;
        hold = '{1'b0, 1'b0}; rval = '{1'b0, 1'b0};
        mem_resp_val = 1'b0; mem_resp_msg = '0;
        reset = 1'b0;
        base = grant_log.size();
        repeat (3) cycle();
        gl = (base < grant_log.size()) ? 77'(grant_log[base]) : 'x;
        chk("post_rst_first_grant", gl, 77'(0));

        p_rrdy = '{70, 70}; p_mrdy = 80; p_val = '{60, 60}; lat_lo = 1; lat_hi = 5;
        repeat (500) cycle();
        drain();
        chk("final_sb0_empty", exp0_q.size(), 0);
        chk("final_sb1_empty", exp1_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pagerank_mem_arbiter.md
PAGERANK_MEM_ARBITER -- requirements
Module: pagerank_mem_arbiter

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the maximum number of outstanding memory requests; legal values are powers of two, 2 or greater.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 req0_msg / req1_msg  in  77  memory request message, `VC_MEM_REQ_MSG_NBITS(8,32,32).
REQ-005 req0_val / req1_val  in  1  requester i presents a valid request.
REQ-006 req0_rdy / req1_rdy  out  1  arbiter accepts the request from requester i.
REQ-007 resp0_msg / resp1_msg  out  47  memory response message, `VC_MEM_RESP_MSG_NBITS(8,32).
REQ-008 resp0_val / resp1_val  out  1  response for requester i is valid.
REQ-009 resp0_rdy / resp1_rdy  in  1  requester i accepts the response.
REQ-010 mem_req_msg / mem_req_val / mem_req_rdy  out / out / in  77 / 1 / 1  shared memory request port.
REQ-011 mem_resp_msg / mem_resp_val / mem_resp_rdy  in / in / out  47 / 1 / 1  shared memory response port; memory returns responses in request order.

Function
REQ-012 The block SHALL share one memory port between two requesters; messages pass through bit-exact, opaque field unmodified.
REQ-013 Arbitration SHALL be round-robin with a 1-bit priority pointer prio: when both requesters are valid, grant requester prio; otherwise grant the sole valid requester.
REQ-014 mem_req_val SHALL be (req0_val | req1_val) & !full; mem_req_msg SHALL be the granted requester's message; combinational, zero cycles of added latency.
REQ-015 reqi_rdy SHALL be mem_req_rdy & !full & (grant == i); the non-granted requester sees rdy = 0.
REQ-016 On a request handshake (mem_req_val & mem_req_rdy), the granted ID SHALL be pushed into a tag FIFO of DEPTH entries, and prio SHALL become the other requester; prio is unchanged if no handshake occurs.
REQ-017 Responses SHALL be routed to the requester whose ID is at the FIFO head: respi_val = mem_resp_val & !empty & (head == i); respi_msg = mem_resp_msg for both ports.
REQ-018 mem_resp_rdy SHALL be !empty & resp[head]_rdy; on a response handshake the FIFO head SHALL be popped.
REQ-019 Occupancy count SHALL be $clog2(DEPTH)+1 bits wide; read and write pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-020 When full, no new request SHALL be accepted, even if a pop occurs in the same cycle; a pop frees the slot for the following cycle.
REQ-021 When empty, mem_resp_rdy = 0 and both resp_val = 0; a memory response arriving while empty SHALL stall, never be dropped or misrouted.
REQ-022 A simultaneous push and pop when neither full nor empty SHALL leave the count unchanged and advance both pointers.
REQ-023 A held request (val high, rdy low) SHALL keep its grant until accepted or until the other requester wins by priority after a handshake; there is no starvation, since each requester waits at most one other grant.

Reset
REQ-024 On reset assertion, asynchronously and at any time: prio = 0, count = 0, pointers = 0.
REQ-025 During reset, outputs follow from empty state: all rdy and val outputs = 0 except as driven by REQ-014 and REQ-015 with !full true.
REQ-026 Reset mid-operation SHALL discard all outstanding tags; responses to pre-reset requests are the integrator's responsibility, and the block stalls them per REQ-021.

Structure
REQ-027 Message widths (77, 47) and the requester-ID type (1 bit) SHALL come from a shared package pagerank_pkg, alongside the existing mem-msgs macros.
REQ-028 The tag FIFO SHALL be a separate sub-module pagerank_tag_fifo (DEPTH, 1-bit data, push/pop/full/empty/head); the arbiter and routing logic live in the top module.

Verification
REQ-029 Both requesters send continuous reads to addresses 0x1000 (port 0) and 0x2000 (port 1), memory always ready -> mem port order 0,1,0,1; each response returns only on its originating port.
REQ-030 Only req1_val = 1 after reset -> immediate grant to port 1 in the same cycle; prio becomes 0.
REQ-031 Memory response latency 10 cycles with DEPTH = 4 -> exactly 4 requests accepted, then req_rdy = 0 until the first response pops.
REQ-032 resp0_rdy = 0 with port 0 at the FIFO head -> mem_resp_rdy = 0, port 1's later response held behind it, no reordering.
REQ-033 Full FIFO with a pop and a new request in the same cycle -> request not accepted that cycle, accepted the next cycle.
REQ-034 Reset asserted with 3 requests outstanding -> count = 0, mem_resp_rdy = 0 immediately, and prio = 0.
